// File: rtl/pacman_motion_ctrl.sv
// rtl/pacman_motion_ctrl.sv - Pac-Man per-frame motion sequencer with wall-map query handshake.
// Optional horizontal tunnel wrap is enabled by defining PACMAN_TUNNEL_WRAP_EN.
module pacman_motion_ctrl #(
  parameter int START_X      = 104,
  parameter int START_Y      = 208,
  parameter int MAZE_W_TILES = 28,
  parameter int MAZE_H_TILES = 36,
  parameter int SPEED_DIV    = 1,
  parameter int ANIM_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_en,
  input  logic       respawn,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       wall_req,
  output logic [4:0] wall_tx,
  output logic [5:0] wall_ty,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [8:0] x_pac,
  output logic [8:0] y_pac,
  output logic       h_flip,
  output logic       v_flip,
  output logic       mouth_open,
  output logic       moving
);

  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DECIDE, ST_Q_DES, ST_Q_CUR} state_t;

  typedef struct packed {
    logic       oor;
    logic       open_local;
    logic [4:0] tx;
    logic [5:0] ty;
  } nb_t;

  localparam logic [8:0] X_MAX = 9'((MAZE_W_TILES - 1) * 8);
  localparam logic [8:0] Y_MAX = 9'((MAZE_H_TILES - 1) * 8);

  state_t     state, nxt_state;
  dir_t       dir, desired, q_dir, step_dir;
  logic [3:0] frame_cnt, anim_cnt;
  logic       resp_pend;
  logic       step_due, aligned, do_step, do_fail, req_nxt;
  logic [4:0] tx_nxt;
  logic [5:0] ty_nxt;
  nb_t        nb_des, nb_cur;

  function automatic dir_t reverse(input dir_t d);
    case (d)
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
    endcase
  endfunction

  // Off-maze neighbours never go to the ROM; only horizontal ones may open up as tunnels.
  function automatic nb_t neighbour(input dir_t d, input logic [8:0] x, input logic [8:0] y);
    int  ntx, nty;
    nb_t r;
    ntx = int'(x[8:3]);
    nty = int'(y[8:3]);
    case (d)
      DIR_LEFT:  ntx = ntx - 1;
      DIR_RIGHT: ntx = ntx + 1;
      DIR_UP:    nty = nty - 1;
      DIR_DOWN:  nty = nty + 1;
    endcase
    r.oor = (ntx < 0) || (ntx >= MAZE_W_TILES) || (nty < 0) || (nty >= MAZE_H_TILES);
`ifdef PACMAN_TUNNEL_WRAP_EN
    r.open_local = r.oor && (nty >= 0) && (nty < MAZE_H_TILES);
`else
    r.open_local = 1'b0;
`endif
    r.tx = ntx[4:0];
    r.ty = nty[5:0];
    return r;
  endfunction

  function automatic logic [8:0] step_x(input dir_t d, input logic [8:0] x);
`ifdef PACMAN_TUNNEL_WRAP_EN
    if (d == DIR_LEFT)  return (x == 9'd0)   ? X_MAX : x - 9'd1;
    if (d == DIR_RIGHT) return (x >= X_MAX)  ? 9'd0  : x + 9'd1;
`else
    if (d == DIR_LEFT)  return (x == 9'd0)   ? 9'd0  : x - 9'd1;
    if (d == DIR_RIGHT) return (x >= X_MAX)  ? X_MAX : x + 9'd1;
`endif
    return x;
  endfunction

  function automatic logic [8:0] step_y(input dir_t d, input logic [8:0] y);
    if (d == DIR_UP)   return (y == 9'd0)  ? 9'd0  : y - 9'd1;
    if (d == DIR_DOWN) return (y >= Y_MAX) ? Y_MAX : y + 9'd1;
    return y;
  endfunction

  assign step_due = frame_tick && game_en && (frame_cnt == 4'(SPEED_DIV - 1));
  assign aligned  = (x_pac[2:0] == 3'd0) && (y_pac[2:0] == 3'd0);
  assign nb_des   = neighbour(desired, x_pac, y_pac);
  assign nb_cur   = neighbour(dir, x_pac, y_pac);

  // The MOVE action is folded into the transition that commits to it, so a step lands
  // on the same edge that resolves the decision or the wall response.
  always_comb begin
    nxt_state = state;
    do_step   = 1'b0;
    do_fail   = 1'b0;
    step_dir  = dir;
    req_nxt   = wall_req;
    tx_nxt    = wall_tx;
    ty_nxt    = wall_ty;
    case (state)
      ST_IDLE: begin
        if (!(respawn || resp_pend) && step_due) nxt_state = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (desired == reverse(dir)) begin
          do_step  = 1'b1;
          step_dir = desired;
        end else if (!aligned) begin
          do_step = 1'b1;
        end else if (desired != dir && !nb_des.oor) begin
          nxt_state = ST_Q_DES;
          req_nxt   = 1'b1;
          tx_nxt    = nb_des.tx;
          ty_nxt    = nb_des.ty;
        end else if (desired != dir && nb_des.open_local) begin
          do_step  = 1'b1;
          step_dir = desired;
        end else begin
          nxt_state = ST_Q_CUR;
          req_nxt   = !nb_cur.oor;
          tx_nxt    = nb_cur.tx;
          ty_nxt    = nb_cur.ty;
        end
      end
      ST_Q_DES: begin
        if (wall_req && wall_ack) begin
          req_nxt = 1'b0;
          if (!wall_hit) begin
            do_step  = 1'b1;
            step_dir = q_dir;
          end else begin
            nxt_state = ST_Q_CUR;
          end
        end
      end
      ST_Q_CUR: begin
        if (wall_req) begin
          if (wall_ack) begin
            req_nxt = 1'b0;
            if (!wall_hit) do_step = 1'b1;
            else           do_fail = 1'b1;
          end
        end else if (nb_cur.oor) begin
          if (nb_cur.open_local) do_step = 1'b1;
          else                   do_fail = 1'b1;
        end else begin
          req_nxt = 1'b1;
          tx_nxt  = nb_cur.tx;
          ty_nxt  = nb_cur.ty;
        end
      end
    endcase
    if (do_step || do_fail) nxt_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      dir        <= DIR_LEFT;
      desired    <= DIR_LEFT;
      q_dir      <= DIR_LEFT;
      frame_cnt  <= 4'd0;
      anim_cnt   <= 4'd0;
      resp_pend  <= 1'b0;
      wall_req   <= 1'b0;
      wall_tx    <= 5'd0;
      wall_ty    <= 6'd0;
      x_pac      <= 9'(START_X);
      y_pac      <= 9'(START_Y);
      h_flip     <= 1'b0;
      v_flip     <= 1'b1;
      mouth_open <= 1'b1;
      moving     <= 1'b0;
    end else begin
      state    <= nxt_state;
      wall_req <= req_nxt;
      wall_tx  <= tx_nxt;
      wall_ty  <= ty_nxt;

      if (btn_up)         desired <= DIR_UP;
      else if (btn_down)  desired <= DIR_DOWN;
      else if (btn_left)  desired <= DIR_LEFT;
      else if (btn_right) desired <= DIR_RIGHT;

      if (frame_tick && game_en)
        frame_cnt <= (frame_cnt >= 4'(SPEED_DIV - 1)) ? 4'd0 : frame_cnt + 4'd1;

      if (state == ST_DECIDE && nxt_state == ST_Q_DES) q_dir <= desired;

      if (do_step) begin
        x_pac  <= step_x(step_dir, x_pac);
        y_pac  <= step_y(step_dir, y_pac);
        dir    <= step_dir;
        h_flip <= (step_dir == DIR_RIGHT) || (step_dir == DIR_DOWN);
        v_flip <= (step_dir == DIR_RIGHT) || (step_dir == DIR_LEFT);
        moving <= 1'b1;
        if (anim_cnt >= 4'(ANIM_DIV - 1)) begin
          anim_cnt   <= 4'd0;
          mouth_open <= ~mouth_open;
        end else begin
          anim_cnt <= anim_cnt + 4'd1;
        end
      end

      if (do_fail) begin
        moving     <= 1'b0;
        mouth_open <= 1'b1;
      end

      // A respawn seen mid-sequence waits for IDLE and then beats any step_due.
      if (state == ST_IDLE && (respawn || resp_pend)) begin
        x_pac     <= 9'(START_X);
        y_pac     <= 9'(START_Y);
        dir       <= DIR_LEFT;
        h_flip    <= 1'b0;
        v_flip    <= 1'b1;
        moving    <= 1'b0;
        resp_pend <= 1'b0;
      end else if (respawn) begin
        resp_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// tb/tb_pacman_motion_ctrl.sv - scoreboard bench for pacman_motion_ctrl (honours PACMAN_TUNNEL_WRAP_EN).
module tb_pacman_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0, game_en = 1'b1, respawn = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       wall_req, wall_ack = 1'b0, wall_hit = 1'b0;
  logic [4:0] wall_tx;
  logic [5:0] wall_ty;
  logic [8:0] x_pac, y_pac;
  logic       h_flip, v_flip, mouth_open, moving;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    logic       mov;
    logic       mouth;
    logic       hf;
    logic       vf;
  } pos_t;

  pos_t        pos_q[$];
  logic [10:0] query_q[$];
  bit          wall_map [0:31][0:63];
  logic        resp_en = 1'b1;
  logic        ack_prev = 1'b0;

  pacman_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_en(game_en), .respawn(respawn),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .wall_req(wall_req), .wall_tx(wall_tx), .wall_ty(wall_ty), .wall_ack(wall_ack),
    .wall_hit(wall_hit), .x_pac(x_pac), .y_pac(y_pac), .h_flip(h_flip), .v_flip(v_flip),
    .mouth_open(mouth_open), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Zero-wait wall-map responder; each query it sees is scored against the expected list.
  always @(negedge clk) begin
    if (ack_prev) check("req_drop", {31'd0, wall_req}, 32'd0);
    if (wall_req && resp_en) begin
      wall_ack = 1'b1;
      wall_hit = wall_map[wall_tx][wall_ty];
      if (query_q.size() == 0) check("query_unexpected", {21'd0, wall_tx, wall_ty}, 32'h7ff);
      else check("query_tile", {21'd0, wall_tx, wall_ty}, {21'd0, query_q.pop_front()});
    end else begin
      wall_ack = 1'b0;
      wall_hit = 1'b0;
    end
    ack_prev = wall_ack;
  end

  task automatic clear_map();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 64; j++) wall_map[i][j] = 1'b0;
  endtask

  task automatic tick_step(input int lat, input logic [8:0] ex, input logic [8:0] ey,
                           input logic emov, input logic emouth, input logic ehf, input logic evf);
    pos_t       p;
    logic [8:0] x0;
    x0 = x_pac;
    pos_q.push_back('{ex, ey, emov, emouth, ehf, evf});
    @(negedge clk) frame_tick = 1'b1;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (e == lat - 1) check("x_early", {23'd0, x_pac}, {23'd0, x0});
    end
    p = pos_q.pop_front();
    check("x_pac", {23'd0, x_pac}, {23'd0, p.x});
    check("y_pac", {23'd0, y_pac}, {23'd0, p.y});
    check("moving", {31'd0, moving}, {31'd0, p.mov});
    check("mouth_open", {31'd0, mouth_open}, {31'd0, p.mouth});
    check("h_flip", {31'd0, h_flip}, {31'd0, p.hf});
    check("v_flip", {31'd0, v_flip}, {31'd0, p.vf});
    repeat (2) @(posedge clk);
    #1 check("req_idle", {31'd0, wall_req}, 32'd0);
  endtask

  task automatic do_respawn();
    @(negedge clk) respawn = 1'b1;
    @(posedge clk); #1;
    respawn = 1'b0;
    check("resp_x", {23'd0, x_pac}, 32'd104);
    check("resp_y", {23'd0, y_pac}, 32'd208);
    check("resp_flip", {30'd0, h_flip, v_flip}, 32'd1);
    check("resp_moving", {31'd0, moving}, 32'd0);
  endtask

  task automatic press(input int which);
    @(negedge clk);
    btn_up    = (which == 0);
    btn_down  = (which == 1);
    btn_left  = (which == 2);
    btn_right = (which == 3);
    @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  function automatic logic walk_mouth(input int i);
    return ((i / 4) % 2) == 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] xb;
    clear_map();
    repeat (2) @(negedge clk);
    check("rst_x", {23'd0, x_pac}, 32'd104);
    check("rst_y", {23'd0, y_pac}, 32'd208);
    check("rst_flip", {30'd0, h_flip, v_flip}, 32'd1);
    check("rst_mouth", {31'd0, mouth_open}, 32'd1);
    check("rst_moving", {31'd0, moving}, 32'd0);
    check("rst_req", {31'd0, wall_req}, 32'd0);
    check("rst_tile", {21'd0, wall_tx, wall_ty}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Aligned, no buttons: one query of the left neighbour, step on the 3rd edge.
    query_q.push_back({5'd12, 6'd26});
    tick_step(3, 9'd103, 9'd208, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reverse while unaligned: no query, step on the 2nd edge, flips follow RIGHT.
    press(3);
    tick_step(2, 9'd104, 9'd208, 1'b1, 1'b1, 1'b1, 1'b1);

    // game_en low blocks new steps.
    game_en = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("gated_x", {23'd0, x_pac}, 32'd104);
    check("gated_req", {31'd0, wall_req}, 32'd0);
    game_en = 1'b1;

    do_respawn();

    // Desired UP blocked at (13,25), fall back to LEFT via (12,26).
    wall_map[13][25] = 1'b1;
    press(0);
    query_q.push_back({5'd13, 6'd25});
    query_q.push_back({5'd12, 6'd26});
    tick_step(5, 9'd103, 9'd208, 1'b1, 1'b1, 1'b0, 1'b1);

    // Fourth successful step toggles the mouth closed.
    tick_step(2, 9'd102, 9'd208, 1'b1, 1'b0, 1'b0, 1'b1);

    do_respawn();

    // Both directions walled: no move, moving drops, mouth forced open.
    wall_map[12][26] = 1'b1;
    query_q.push_back({5'd13, 6'd25});
    query_q.push_back({5'd12, 6'd26});
    tick_step(5, 9'd104, 9'd208, 1'b0, 1'b1, 1'b0, 1'b1);

    // Walk left across an open row down to x=0.
    clear_map();
    press(2);
    for (int i = 1; i <= 104; i++) begin
      xb = 9'(105 - i);
      if (xb[2:0] == 3'd0) begin
        query_q.push_back({5'(xb[8:3] - 6'd1), 6'd26});
        tick_step(3, xb - 9'd1, 9'd208, 1'b1, walk_mouth(i), 1'b0, 1'b1);
      end else begin
        tick_step(2, xb - 9'd1, 9'd208, 1'b1, walk_mouth(i), 1'b0, 1'b1);
      end
    end

    // Left edge of the maze: resolved without a query.
`ifdef PACMAN_TUNNEL_WRAP_EN
    tick_step(3, 9'd216, 9'd208, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    tick_step(3, 9'd0, 9'd208, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    check("queries_left", query_q.size(), 32'd0);

    // Asynchronous reset while a query is outstanding.
    resp_en = 1'b0;
    press(0);
    @(negedge clk) frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1;
    check("hold_req", {31'd0, wall_req}, 32'd1);
`ifdef PACMAN_TUNNEL_WRAP_EN
    check("hold_tile", {21'd0, wall_tx, wall_ty}, {21'd0, 5'd27, 6'd25});
`else
    check("hold_tile", {21'd0, wall_tx, wall_ty}, {21'd0, 5'd0, 6'd25});
`endif
    #2 rst = 1'b0;
    #1;
    check("arst_req", {31'd0, wall_req}, 32'd0);
    check("arst_x", {23'd0, x_pac}, 32'd104);
    check("arst_y", {23'd0, y_pac}, 32'd208);
    check("arst_flip", {30'd0, h_flip, v_flip}, 32'd1);
    check("arst_mouth", {31'd0, mouth_open}, 32'd1);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pacman_motion_ctrl.md
Name: pacman_motion_ctrl

Overview:
- Per-frame motion sequencer for the Pac-Man sprite renderer.
- Latches the joystick direction and queries the maze wall map through a req/ack handshake.
- Steps the sprite position one pixel at a time and drives its position, orientation-flip and mouth-frame inputs.
- Sits between the input debouncer, the maze tile ROM arbiter and the sprite renderer. Runs in the pixel clock domain.

Parameters:
- START_X, 104: reset/respawn x pixel (tile 13, aligned).
- START_Y, 208: reset/respawn y pixel (tile 26, aligned).
- MAZE_W_TILES, 28: maze width in 8-px tiles.
- MAZE_H_TILES, 36: maze height in 8-px tiles.
- SPEED_DIV, 1: frame ticks per one-pixel step (1..15).
- ANIM_DIV, 4: pixel steps per mouth toggle (1..15).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame.
- game_en  in  1  steps allowed when high.
- respawn  in  1  one-cycle pulse: reload start position.
- btn_up / btn_down / btn_left / btn_right  in  1 each  debounced, level.
- wall_req  out  1  query valid; held until ack.
- wall_tx  out  5  queried tile column.
- wall_ty  out  6  queried tile row.
- wall_ack  in  1  response strobe.
- wall_hit  in  1  tile is wall; valid with wall_ack.
- x_pac  out  9  sprite x (pixels).
- y_pac  out  9  sprite y (pixels).
- h_flip  out  1  renderer orientation select.
- v_flip  out  1  renderer orientation select.
- mouth_open  out  1  1 = open-mouth frame.
- moving  out  1  last step succeeded.

Behaviour:
- Reset (rst low, immediate, any state): x_pac=START_X, y_pac=START_Y, dir=LEFT, desired=LEFT, h_flip=0, v_flip=1, mouth_open=1, moving=0, wall_req=0, tile fields 0, counters 0, state IDLE. All outputs are registered.
- Orientation map:
  - RIGHT: h_flip=1, v_flip=1.
  - LEFT: h_flip=0, v_flip=1.
  - DOWN: h_flip=1, v_flip=0.
  - UP: h_flip=0, v_flip=0.
  - Flips update in the same cycle dir changes.
- Desired direction: sampled every cycle. Priority up > down > left > right. Held when no button is pressed.
- Frame counter: increments on each frame_tick when game_en=1. On reaching SPEED_DIV-1 it wraps to 0 and raises step_due.
  - A tick arriving while not IDLE is counted, but a step_due generated then is dropped (no queueing).
- respawn: in IDLE, loads the reset position, dir=LEFT and moving=0. Outside IDLE it is held pending until IDLE is re-entered. The pending respawn takes precedence over a simultaneous step_due.
- Aligned means x_pac[2:0]==0 and y_pac[2:0]==0. Tile = pixel>>3. Neighbour tile is tx±1 or ty±1.
- Out-of-range neighbour (tx=-1 or tx=MAZE_W_TILES; ty likewise) is resolved locally with no query: wall, except as given under Optional Feature.
- FSM:
  - IDLE → DECIDE on step_due.
  - DECIDE:
    - desired is the reverse of dir: dir←desired, → MOVE.
    - not aligned: → MOVE.
    - aligned and desired≠dir: → Q_DES.
    - aligned and desired==dir: → Q_CUR.
  - Q_DES: wall_req=1 with desired's neighbour. On wall_ack: hit=0 → dir←desired, → MOVE; hit=1 → Q_CUR.
  - Q_CUR: query dir's neighbour. On wall_ack: hit=0 → MOVE; hit=1 → moving←0, → IDLE.
  - MOVE: step one pixel in dir, moving←1, → IDLE.
- Handshake:
  - wall_req and tile fields are stable until the ack cycle.
  - wall_ack may arrive in the first req cycle.
  - wall_req drops the cycle after ack.
  - Back-to-back queries (Q_DES then Q_CUR) deassert wall_req for ≥1 cycle in between.
  - wall_ack while wall_req=0 is ignored.
- Latency, counted from the edge that samples step_due:
  - Unaligned: position updates on the 2nd edge.
  - Single query with zero-wait ack: 3rd edge.
- Mouth: step counter increments per MOVE. On reaching ANIM_DIV-1, mouth_open toggles. When a step fails, mouth_open is forced to 1.
- game_en low: no new steps; an in-flight sequence completes.

Optional Feature:
- Macro: PACMAN_TUNNEL_WRAP_EN.
- Defined:
  - Out-of-range horizontal neighbour counts as open.
  - Moving LEFT from x=0 sets x=(MAZE_W_TILES-1)*8 (216).
  - Moving RIGHT from 216 sets x=0.
  - Vertical out-of-range stays wall.
- Undefined: every out-of-range neighbour is wall; x is clamped to 0..216.

Test Plan:
- rst low during Q_DES with wall_req=1 → same cycle: wall_req=0, x_pac=104, y_pac=208, h_flip=0, v_flip=1, mouth_open=1.
- Reset, no buttons, responder always hit=0, one frame_tick → single query of (12,26); x_pac=103 on 3rd edge; moving=1.
- x=104/y=208, press up; responder hit=1 for (13,25) and hit=0 for (12,26) → two queries in that order; dir stays LEFT; x=103.
- Same setup with both tiles hit=1 → x unchanged; moving=0; mouth_open=1; wall_req idle afterwards.
- x=103 moving LEFT, press right, tick → no wall_req; x=104 on 2nd edge; h_flip=1, v_flip=1.
- x=0, y=208, LEFT, tick → with macro: no query, x=216. Without macro: no query, x stays 0, moving=0.
